// File: rtl/mesh_term_fifo_bank.sv
// Bank of NTERM independent show-ahead FIFOs between the traffic drivers and the mesh terminal ports.
// Each channel supports a reject or drop-oldest overflow policy, flush, and saturating overflow/underflow statistics.
module mesh_term_fifo_bank #(
  parameter int NTERM       = 16,
  parameter int pckg_sz     = 40,
  parameter int fifo_depth  = 8,
  parameter int AF_TH       = 6,
  parameter int DROP_OLDEST = 0,
  parameter int CNT_W       = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NTERM-1:0]                  push,
  input  logic [NTERM*pckg_sz-1:0]          data_in,
  input  logic [NTERM-1:0]                  flush,
  input  logic [NTERM-1:0]                  popin,
  output logic [NTERM-1:0]                  pndng_i_in,
  output logic [NTERM*pckg_sz-1:0]          data_out_i_in,
  output logic [NTERM-1:0]                  almost_full,
  output logic [NTERM-1:0]                  full,
  output logic [NTERM*$clog2(fifo_depth+1)-1:0] count,
  output logic [NTERM*CNT_W-1:0]            ovf_cnt,
  output logic [NTERM-1:0]                  udf_flag
);

  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = $clog2(fifo_depth);

  // Modulo-depth increment so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar g = 0; g < NTERM; g++) begin : g_ch
    logic [pckg_sz-1:0] r_mem [fifo_depth];
    logic [PW-1:0]      r_rd;
    logic [PW-1:0]      r_wr;
    logic [CW-1:0]      r_cnt;
    logic [CNT_W-1:0]   r_ovf;
    logic               r_udf;

    logic w_empty, w_full, w_pop, w_wr, w_ovf, w_rd_adv, w_udf;

    always_comb begin
      w_empty  = (r_cnt == '0);
      w_full   = (r_cnt == CW'(fifo_depth));
      w_pop    = 1'b0;
      w_wr     = 1'b0;
      w_ovf    = 1'b0;
      w_rd_adv = 1'b0;
      w_udf    = 1'b0;
      if (!flush[g]) begin
        w_pop    = popin[g] && !w_empty;
        w_udf    = popin[g] && w_empty;
        // A pop on a full channel frees the slot, so the push is not an overflow.
        w_ovf    = push[g] && w_full && !w_pop;
        w_wr     = push[g] && (!w_full || w_pop || (DROP_OLDEST != 0));
        w_rd_adv = w_pop || (w_ovf && (DROP_OLDEST != 0));
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && w_wr) r_mem[r_wr] <= data_in[g*pckg_sz +: pckg_sz];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
        r_ovf <= '0;
        r_udf <= 1'b0;
      end else begin
        if (flush[g]) begin
          r_rd  <= '0;
          r_wr  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_wr)     r_wr <= f_inc(r_wr);
          if (w_rd_adv) r_rd <= f_inc(r_rd);
          if (w_wr && !w_rd_adv)      r_cnt <= r_cnt + 1'b1;
          else if (!w_wr && w_rd_adv) r_cnt <= r_cnt - 1'b1;
        end
        if (w_ovf && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
        if (w_udf)                  r_udf <= 1'b1;
      end
    end

    assign pndng_i_in[g]                        = !w_empty;
    assign data_out_i_in[g*pckg_sz +: pckg_sz]  = w_empty ? '0 : r_mem[r_rd];
    assign almost_full[g]                       = (r_cnt >= CW'(AF_TH));
    assign full[g]                              = w_full;
    assign count[g*CW +: CW]                    = r_cnt;
    assign ovf_cnt[g*CNT_W +: CNT_W]            = r_ovf;
    assign udf_flag[g]                          = r_udf;
  end

endmodule

// File: doc/mesh_term_fifo_bank.md
Name: mesh_term_fifo_bank

Overview:
- Parametrised bank of NTERM independent terminal-side FIFOs feeding the mesh_gnrtr inputs.
- Successor of the single-FIFO per-driver model: it generalises terminal count, width and depth.
- Adds a selectable overflow policy (reject or drop-oldest), almost-full flags, per-channel flush, and saturating overflow/underflow statistics.
- Push side connects to the generator/driver; pop side connects directly to the mesh ports pndng_i_in / data_out_i_in / popin.

Parameters:
- NTERM, 16, number of terminals (ROWS*2+COLUMS*2; 16 for a 4x4 mesh).
- pckg_sz, 40, packet width in bits.
- fifo_depth, 8, entries per channel; any value >= 2.
- AF_TH, 6, almost-full threshold; valid range 1..fifo_depth.
- DROP_OLDEST, 0, overflow policy: 0 = reject new packet, 1 = overwrite oldest entry.
- CNT_W, 8, width of each statistics counter.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- push, input, NTERM, per-channel write strobe.
- data_in, input, NTERM*pckg_sz, write data; channel i occupies bits [i*pckg_sz +: pckg_sz].
- flush, input, NTERM, per-channel synchronous clear.
- popin, input, NTERM, per-channel pop issued by the mesh.
- pndng_i_in, output, NTERM, channel non-empty.
- data_out_i_in, output, NTERM*pckg_sz, head entry of each channel (show-ahead); same packing as data_in.
- almost_full, output, NTERM, occupancy >= AF_TH.
- full, output, NTERM, occupancy == fifo_depth.
- count, output, NTERM*$clog2(fifo_depth+1), per-channel occupancy.
- ovf_cnt, output, NTERM*CNT_W, per-channel overflow events; saturating.
- udf_flag, output, NTERM, sticky flag: pop attempted while empty.

Behaviour:
- Reset, sampled on clk, clears every channel:
  - rd/wr pointers and count = 0.
  - pndng_i_in, full, almost_full = 0.
  - data_out_i_in = 0.
  - ovf_cnt = 0, udf_flag = 0.
  - Storage contents need not be cleared.
  - Reset asserted mid-operation discards all queued packets the next edge; push/pop in that cycle are ignored.
- Channels are fully independent; no cross-channel interaction.
- Write: push=1 and not full -> entry stored at wr pointer; wr pointer advances modulo fifo_depth; count+1.
- Read, show-ahead:
  - data_out_i_in shows the head entry combinationally from storage; it is driven 0 when the channel is empty.
  - pndng_i_in = (count != 0), registered-state derived, no combinational path from push.
  - popin=1 with pndng=1 -> rd pointer advances and count-1 at the edge.
- Latency: a push into an empty channel raises pndng the following cycle. No same-cycle fall-through.
- push and popin in the same cycle:
  - Not empty and not full: both succeed, count unchanged.
  - Empty: push succeeds, pop is treated as underflow -> count becomes 1, udf_flag set.
  - Full: both succeed, no overflow counted, count stays fifo_depth.
- push while full, no pop:
  - DROP_OLDEST=0: packet discarded, state unchanged, ovf_cnt+1.
  - DROP_OLDEST=1: rd and wr pointers both advance, new packet replaces the oldest, count stays fifo_depth, ovf_cnt+1.
- popin while empty (without push): no state change except udf_flag <= 1. udf_flag stays set until reset.
- flush=1: pointers and count cleared at the edge. Flush wins over push/pop in the same cycle; those push/pop are dropped and not counted. ovf_cnt and udf_flag are preserved.
- ovf_cnt saturates at 2^CNT_W-1, with no wrap.
- Pointer wrap: pointers return to 0 after index fifo_depth-1, including non-power-of-two depths.
- full and almost_full are combinational from count.

Test Plan:
- Reset with DROP_OLDEST=0: push ch3 with 0xA5 -> pndng_i_in[3]=1 one cycle later, data_out ch3=0xA5, count=1. Pop -> pndng=0, data_out=0.
- Fill ch0 with 1..8 (depth 8): full=1 and almost_full=1 from count 6; 9th push 0x99 rejected, ovf_cnt[0]=1; pops return 1..8 in order.
- DROP_OLDEST=1: fill ch5 with 1..8, push 9 and 10 -> count=8, ovf_cnt=2, pops return 3..10.
- Simultaneous push+pop on full ch1 -> count stays 8, ovf_cnt=0; simultaneous push+pop on empty ch2 -> count=1, udf_flag[2]=1.
- Flush ch7 holding 4 entries while push=1 -> count=0, pndng=0, pushed packet lost; other channels unaffected.
- CNT_W=2: 5 rejected pushes -> ovf_cnt=3 (saturated). Reset asserted with 3 entries queued -> all outputs 0 the next cycle.
